// File: rtl/shift_reg_univ_pkg.sv
// Purpose: shared mode encodings and shift-direction type for the universal
// shift register and its word counter.
package shift_pkg;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SHR  = 2'b01;
  localparam logic [1:0] MODE_SHL  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  typedef enum logic {
    DIR_R = 1'b0,
    DIR_L = 1'b1
  } dir_e;

endpackage

// File: rtl/shift_reg_univ_if.sv
// Purpose: control/data bundle of the universal shift register.
// Ports: en, mode, sir, sil, pin driven by master; pout, sor, sol, bit_cnt,
// word_done driven by slave (the register).
interface shift_reg_univ_if #(
  parameter int unsigned WIDTH = 8
);
  localparam int unsigned CW = $clog2(WIDTH);

  logic             en;
  logic [1:0]       mode;
  logic             sir;
  logic             sil;
  logic [WIDTH-1:0] pin;
  logic [WIDTH-1:0] pout;
  logic             sor;
  logic             sol;
  logic [CW-1:0]    bit_cnt;
  logic             word_done;

  modport master (
    output en, mode, sir, sil, pin,
    input  pout, sor, sol, bit_cnt, word_done
  );

  modport slave (
    input  en, mode, sir, sil, pin,
    output pout, sor, sol, bit_cnt, word_done
  );
endinterface

// File: rtl/shift_reg_univ_word_counter.sv
// Purpose: counts consecutive same-direction shifts modulo WIDTH and pulses
// word_done for one cycle after each full word.
// Ports: clk, rst (sync, active-high), shift_valid/shift_dir (a shift edge and
// its direction), clear (parallel load), bit_cnt, word_done.
module shift_word_counter
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     shift_valid,
  input  dir_e                     shift_dir,
  input  logic                     clear,
  output logic [$clog2(WIDTH)-1:0] bit_cnt,
  output logic                     word_done
);
  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  dir_e last_dir;

  // Explicit compare against WIDTH-1 so non-power-of-two widths wrap correctly.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt   <= '0;
      word_done <= 1'b0;
      last_dir  <= DIR_R;
    end else begin
      word_done <= 1'b0;
      if (clear) begin
        bit_cnt <= '0;
      end else if (shift_valid) begin
        if (shift_dir == last_dir) begin
          if (bit_cnt == LAST) begin
            bit_cnt   <= '0;
            word_done <= 1'b1;
          end else begin
            bit_cnt <= CW'(bit_cnt + CW'(1));
          end
        end else begin
          // A direction change starts a new word; this shift is its first bit.
          bit_cnt  <= CW'(1);
          last_dir <= shift_dir;
        end
      end
    end
  end

endmodule

// File: rtl/shift_reg_univ.sv
// Purpose: parametrised universal shift register (hold, shift right, shift
// left, parallel load) with serial/parallel outputs and word-complete pulse.
// Ports: clk, rst (sync, active-high), bus (slave side of shift_reg_univ_if).
module shift_reg_univ
  import shift_pkg::*;
#(
  parameter int unsigned      WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic           clk,
  input  logic           rst,
  shift_reg_univ_if.slave bus
);
  logic [WIDTH-1:0] q;
  logic             shift_valid_c;
  logic             clear_c;
  dir_e             shift_dir_c;

  // Data register; unselected serial/parallel inputs never reach q.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= RST_VAL;
    end else if (bus.en) begin
      case (bus.mode)
        MODE_SHR:  q <= {bus.sir, q[WIDTH-1:1]};
        MODE_SHL:  q <= {q[WIDTH-2:0], bus.sil};
        MODE_LOAD: q <= bus.pin;
        default:   q <= q;
      endcase
    end
  end

  // Decode the counter's view of this cycle's operation.
  always_comb begin
    shift_valid_c = 1'b0;
    clear_c       = 1'b0;
    shift_dir_c   = DIR_R;
    if (bus.en) begin
      case (bus.mode)
        MODE_SHR:  shift_valid_c = 1'b1;
        MODE_SHL: begin
          shift_valid_c = 1'b1;
          shift_dir_c   = DIR_L;
        end
        MODE_LOAD: clear_c = 1'b1;
        default:   shift_valid_c = 1'b0;
      endcase
    end
  end

  shift_word_counter #(
    .WIDTH(WIDTH)
  ) u_cnt (
    .clk         (clk),
    .rst         (rst),
    .shift_valid (shift_valid_c),
    .shift_dir   (shift_dir_c),
    .clear       (clear_c),
    .bit_cnt     (bus.bit_cnt),
    .word_done   (bus.word_done)
  );

  assign bus.pout = q;
  assign bus.sor  = q[0];
  assign bus.sol  = q[WIDTH-1];

endmodule

// File: tb/tb_shift_reg_univ.sv
// Purpose: scoreboard bench for shift_reg_univ at WIDTH=4 and WIDTH=5.
// Drivers push hand-computed expected state per edge; monitors pop and compare.
module tb_shift_reg_univ;

  typedef struct {
    logic [4:0] pout;
    logic [2:0] cnt;
    logic       done;
  } exp_t;

  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t qa[$];
  exp_t qb[$];

  always #5 clk = ~clk;

  shift_reg_univ_if #(.WIDTH(4)) ifa ();
  shift_reg_univ_if #(.WIDTH(5)) ifb ();

  shift_reg_univ #(.WIDTH(4), .RST_VAL(4'b0000)) dut_a (
    .clk (clk),
    .rst (rst_a),
    .bus (ifa.slave)
  );

  shift_reg_univ #(.WIDTH(5), .RST_VAL(5'b00000)) dut_b (
    .clk (clk),
    .rst (rst_b),
    .bus (ifb.slave)
  );

  task automatic check(input string name, input int idx, input logic [7:0] act,
                       input logic [7:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s step %0d: got %b required %b", name, idx, act, req);
    end
  endtask

  task automatic step_a(input logic r, input logic e, input logic [1:0] m,
                        input logic si_r, input logic si_l, input logic [3:0] p,
                        input logic [3:0] ep, input logic [1:0] ec, input logic ed);
    @(negedge clk);
    rst_a    = r;
    ifa.en   = e;
    ifa.mode = m;
    ifa.sir  = si_r;
    ifa.sil  = si_l;
    ifa.pin  = p;
    qa.push_back('{pout: 5'(ep), cnt: 3'(ec), done: ed});
  endtask

  task automatic step_b(input logic r, input logic e, input logic [1:0] m,
                        input logic si_r, input logic [4:0] ep,
                        input logic [2:0] ec, input logic ed);
    @(negedge clk);
    rst_b    = r;
    ifb.en   = e;
    ifb.mode = m;
    ifb.sir  = si_r;
    ifb.sil  = 1'bx;
    ifb.pin  = 'x;
    qb.push_back('{pout: ep, cnt: ec, done: ed});
  endtask

  // Monitor for WIDTH=4 instance.
  int ia = 0;
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (qa.size() > 0) begin
      e = qa.pop_front();
      check("a_pout", ia, 8'(ifa.pout), 8'(e.pout[3:0]));
      check("a_cnt",  ia, 8'(ifa.bit_cnt), 8'(e.cnt[1:0]));
      check("a_done", ia, 8'(ifa.word_done), 8'(e.done));
      check("a_sor",  ia, 8'(ifa.sor), 8'(e.pout[0]));
      check("a_sol",  ia, 8'(ifa.sol), 8'(e.pout[3]));
      ia++;
    end
  end

  // Monitor for WIDTH=5 instance.
  int ib = 0;
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (qb.size() > 0) begin
      e = qb.pop_front();
      check("b_pout", ib, 8'(ifb.pout), 8'(e.pout));
      check("b_cnt",  ib, 8'(ifb.bit_cnt), 8'(e.cnt));
      check("b_done", ib, 8'(ifb.word_done), 8'(e.done));
      check("b_sor",  ib, 8'(ifb.sor), 8'(e.pout[0]));
      check("b_sol",  ib, 8'(ifb.sol), 8'(e.pout[4]));
      ib++;
    end
  end

  initial begin
    rst_a = 1'b1; ifa.en = 1'b0; ifa.mode = 2'b00; ifa.sir = 1'b0; ifa.sil = 1'b0; ifa.pin = '0;
    rst_b = 1'b1; ifb.en = 1'b0; ifb.mode = 2'b00; ifb.sir = 1'b0; ifb.sil = 1'b0; ifb.pin = '0;

    // reset
    step_a(1, 0, 2'b00, 0, 0, 4'h0, 4'b0000, 2'd0, 0);
    // serial-in right: 1,0,0,1 then continue with zeros
    step_a(0, 1, 2'b01, 1, 1'bx, 4'hx, 4'b1000, 2'd1, 0);
    step_a(0, 1, 2'b01, 0, 1'bx, 4'hx, 4'b0100, 2'd2, 0);
    step_a(0, 1, 2'b01, 0, 1'bx, 4'hx, 4'b0010, 2'd3, 0);
    step_a(0, 1, 2'b01, 1, 1'bx, 4'hx, 4'b1001, 2'd0, 1);
    step_a(0, 1, 2'b01, 0, 0,    4'h0, 4'b0100, 2'd1, 0);
    step_a(0, 1, 2'b01, 0, 0,    4'h0, 4'b0010, 2'd2, 0);
    step_a(0, 1, 2'b01, 0, 0,    4'h0, 4'b0001, 2'd3, 0);
    step_a(0, 1, 2'b01, 0, 0,    4'h0, 4'b0000, 2'd0, 1);
    // load then shift left with sil=0
    step_a(0, 1, 2'b11, 1'bx, 1'bx, 4'b1010, 4'b1010, 2'd0, 0);
    step_a(0, 1, 2'b10, 1'bx, 0, 4'hx, 4'b0100, 2'd1, 0);
    step_a(0, 1, 2'b10, 1'bx, 0, 4'hx, 4'b1000, 2'd2, 0);
    step_a(0, 1, 2'b10, 1'bx, 0, 4'hx, 4'b0000, 2'd3, 0);
    step_a(0, 1, 2'b10, 1'bx, 0, 4'hx, 4'b0000, 2'd0, 1);
    // direction change mid-word
    step_a(0, 1, 2'b01, 1, 0, 4'h0, 4'b1000, 2'd1, 0);
    step_a(0, 1, 2'b01, 1, 0, 4'h0, 4'b1100, 2'd2, 0);
    step_a(0, 1, 2'b10, 0, 1, 4'h0, 4'b1001, 2'd1, 0);
    step_a(0, 1, 2'b10, 0, 0, 4'h0, 4'b0010, 2'd2, 0);
    step_a(0, 1, 2'b10, 0, 1, 4'h0, 4'b0101, 2'd3, 0);
    step_a(0, 1, 2'b10, 0, 1, 4'h0, 4'b1011, 2'd0, 1);
    // reach bit_cnt=2, then en=0 for 5 cycles, then resume
    step_a(0, 1, 2'b01, 0, 0, 4'h0, 4'b0101, 2'd1, 0);
    step_a(0, 1, 2'b01, 1, 0, 4'h0, 4'b1010, 2'd2, 0);
    for (int i = 0; i < 5; i++) step_a(0, 0, 2'b01, 1, 1, 4'hf, 4'b1010, 2'd2, 0);
    step_a(0, 1, 2'b01, 1, 1'bx, 4'hx, 4'b1101, 2'd3, 0);
    step_a(0, 1, 2'b01, 0, 1'bx, 4'hx, 4'b0110, 2'd0, 1);
    step_a(0, 1, 2'b00, 1, 1, 4'hf, 4'b0110, 2'd0, 0);
    // reach bit_cnt=3 then reset alongside load
    step_a(0, 1, 2'b01, 1, 0, 4'h0, 4'b1011, 2'd1, 0);
    step_a(0, 1, 2'b01, 1, 0, 4'h0, 4'b1101, 2'd2, 0);
    step_a(0, 1, 2'b01, 0, 0, 4'h0, 4'b0110, 2'd3, 0);
    step_a(1, 1, 2'b11, 0, 0, 4'hf, 4'b0000, 2'd0, 0);
    // after reset last direction is right: a left shift restarts the count
    step_a(0, 1, 2'b10, 0, 1, 4'h0, 4'b0001, 2'd1, 0);
    step_a(0, 1, 2'b01, 0, 0, 4'h0, 4'b0000, 2'd1, 0);
    step_a(0, 0, 2'b00, 0, 0, 4'h0, 4'b0000, 2'd1, 0);

    // WIDTH=5: 10 continuous right shifts
    step_b(1, 0, 2'b00, 0, 5'b00000, 3'd0, 0);
    step_b(0, 1, 2'b01, 1, 5'b10000, 3'd1, 0);
    step_b(0, 1, 2'b01, 0, 5'b01000, 3'd2, 0);
    step_b(0, 1, 2'b01, 1, 5'b10100, 3'd3, 0);
    step_b(0, 1, 2'b01, 0, 5'b01010, 3'd4, 0);
    step_b(0, 1, 2'b01, 1, 5'b10101, 3'd0, 1);
    step_b(0, 1, 2'b01, 1, 5'b11010, 3'd1, 0);
    step_b(0, 1, 2'b01, 0, 5'b01101, 3'd2, 0);
    step_b(0, 1, 2'b01, 0, 5'b00110, 3'd3, 0);
    step_b(0, 1, 2'b01, 1, 5'b10011, 3'd4, 0);
    step_b(0, 1, 2'b01, 1, 5'b11001, 3'd0, 1);
    step_b(0, 1, 2'b00, 0, 5'b11001, 3'd0, 0);

    // bounded drain of both scoreboards
    for (int i = 0; i < 10 && (qa.size() + qb.size()) > 0; i++) @(posedge clk);
    #2;
    n_cmp++;
    if (qa.size() + qb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending required 0", qa.size() + qb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
